// File: rtl/mem_arbiter_2p_pkg.sv
// Shared types and constants for the two-port SRAM arbiter and its response pipe.
package mem_arb_pkg;

    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
        logic     err;
        logic     we;
    } resp_tag_t;

    localparam int unsigned MAX_LATENCY = 3;
    localparam logic [31:0] ERR_RDATA   = 32'h0;

    function automatic port_id_e other_port(input port_id_e p);
        port_id_e r;
        case (p)
            PORT1:   r = PORT2;
            PORT2:   r = PORT1;
            default: r = PORT1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_2p_resp_pipe.sv
// Fixed-depth shift register carrying response tags so each grant's response
// surfaces exactly MEM_LATENCY cycles later, aligned with the SRAM read data.
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  resp_tag_t push_i,
    output resp_tag_t head_o
);

    resp_tag_t r_stage [MEM_LATENCY];

    // Tag shift register; reset drops every in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= push_i;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                r_stage[i] <= r_stage[i - 1];
            end
        end
    end

    assign head_o = r_stage[MEM_LATENCY - 1];

endmodule

// File: rtl/mem_arbiter_2p.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between two
// req/gnt/rvalid ports, with in-order response routing and a conflict counter.
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned AW          = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,

    input  logic          p1_req_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic          p1_err_o,
    input  logic          p1_we_i,
    input  logic [3:0]    p1_be_i,
    input  logic [31:0]   p1_addr_i,
    input  logic [31:0]   p1_wdata_i,
    output logic [31:0]   p1_rdata_o,

    input  logic          p2_req_i,
    output logic          p2_gnt_o,
    output logic          p2_rvalid_o,
    output logic          p2_err_o,
    input  logic          p2_we_i,
    input  logic [3:0]    p2_be_i,
    input  logic [31:0]   p2_addr_i,
    input  logic [31:0]   p2_wdata_i,
    output logic [31:0]   p2_rdata_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,

    output logic [31:0]   conflict_cnt_o
);

    port_id_e    r_rr_prio;
    logic [31:0] r_conflict_cnt;

    logic        w_both_req;
    logic        w_gnt1;
    logic        w_gnt2;
    logic        w_any_gnt;
    port_id_e    w_win;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_in_range;
    resp_tag_t   w_push_tag;
    resp_tag_t   w_head;
    logic [31:0] w_resp_rdata;
    logic        w_p1_hit;
    logic        w_p2_hit;

    assign w_both_req = p1_req_i & p2_req_i;

    // Grant selection: a lone requester wins, a tie goes to the round-robin pointer.
    always_comb begin
        w_gnt1 = 1'b0;
        w_gnt2 = 1'b0;
        if (enable_i) begin
            if (w_both_req) begin
                if (r_rr_prio == PORT1) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt2 = 1'b1;
                end
            end else if (p1_req_i) begin
                w_gnt1 = 1'b1;
            end else if (p2_req_i) begin
                w_gnt2 = 1'b1;
            end else begin
                w_gnt1 = 1'b0;
                w_gnt2 = 1'b0;
            end
        end else begin
            w_gnt1 = 1'b0;
            w_gnt2 = 1'b0;
        end
    end

    assign w_any_gnt = w_gnt1 | w_gnt2;
    assign p1_gnt_o  = w_gnt1;
    assign p2_gnt_o  = w_gnt2;

    // Winner's request fields; port 1 is the idle default.
    always_comb begin
        w_win   = PORT1;
        w_we    = p1_we_i;
        w_be    = p1_be_i;
        w_addr  = p1_addr_i;
        w_wdata = p1_wdata_i;
        if (w_gnt2) begin
            w_win   = PORT2;
            w_we    = p2_we_i;
            w_be    = p2_be_i;
            w_addr  = p2_addr_i;
            w_wdata = p2_wdata_i;
        end else begin
            w_win   = PORT1;
        end
    end

    // Any byte address bit at or above the SRAM size marks the access as out of range.
    assign w_in_range  = ((w_addr >> (AW + 2)) == 32'h0);

    assign mem_req_o   = w_any_gnt & w_in_range;
    assign mem_we_o    = w_any_gnt & w_in_range & w_we;
    assign mem_be_o    = w_be;
    assign mem_addr_o  = w_addr[AW+1:2];
    assign mem_wdata_o = w_wdata;

    // Tag for the current grant, pushed into the latency-matched pipe.
    always_comb begin
        w_push_tag       = '0;
        w_push_tag.valid = w_any_gnt;
        w_push_tag.port  = w_win;
        w_push_tag.err   = ~w_in_range;
        w_push_tag.we    = w_we;
    end

    mem_arb_resp_pipe #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (w_push_tag),
        .head_o (w_head)
    );

    assign w_p1_hit     = w_head.valid & (w_head.port == PORT1);
    assign w_p2_hit     = w_head.valid & (w_head.port == PORT2);
    assign w_resp_rdata = (w_head.we | w_head.err) ? ERR_RDATA : mem_rdata_i;

    assign p1_rvalid_o  = w_p1_hit;
    assign p2_rvalid_o  = w_p2_hit;
    assign p1_err_o     = w_p1_hit & w_head.err;
    assign p2_err_o     = w_p2_hit & w_head.err;
    assign p1_rdata_o   = w_p1_hit ? w_resp_rdata : ERR_RDATA;
    assign p2_rdata_o   = w_p2_hit ? w_resp_rdata : ERR_RDATA;

    // Round-robin pointer moves to the loser only when a grant is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_prio <= PORT1;
        end else if (w_any_gnt) begin
            r_rr_prio <= other_port(w_win);
        end else begin
            r_rr_prio <= r_rr_prio;
        end
    end

    // Saturating count of cycles with both ports requesting, regardless of enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict_cnt <= 32'h0;
        end else if (w_both_req && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end else begin
            r_conflict_cnt <= r_conflict_cnt;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Randomised and directed bench for mem_arbiter_2p: instance 0 uses latency 1,
// instance 1 latency 3; a transaction-level model predicts every port cycle.
module tb_mem_arbiter_2p;

    localparam int MW  = 64;
    localparam int AWT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        en [2];
    logic        p1_req [2], p1_we [2], p1_gnt [2], p1_rvalid [2], p1_err [2];
    logic        p2_req [2], p2_we [2], p2_gnt [2], p2_rvalid [2], p2_err [2];
    logic [3:0]  p1_be [2], p2_be [2];
    logic [31:0] p1_addr [2], p1_wdata [2], p1_rdata [2];
    logic [31:0] p2_addr [2], p2_wdata [2], p2_rdata [2];
    logic        mem_req [2], mem_we [2];
    logic [3:0]  mem_be [2];
    logic [AWT-1:0] mem_addr [2];
    logic [31:0] mem_wdata [2], mem_rdata [2], cnt_o [2];

    logic [31:0] init_img [MW];
    logic        preload;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem [MW];
        logic [31:0] rd_pipe [L];

        mem_arbiter_2p #(.MEM_WORDS(MW), .MEM_LATENCY(L)) u_dut (
            .clk_i(clk), .rst_ni(rst_n[g]), .enable_i(en[g]),
            .p1_req_i(p1_req[g]), .p1_gnt_o(p1_gnt[g]), .p1_rvalid_o(p1_rvalid[g]),
            .p1_err_o(p1_err[g]), .p1_we_i(p1_we[g]), .p1_be_i(p1_be[g]),
            .p1_addr_i(p1_addr[g]), .p1_wdata_i(p1_wdata[g]), .p1_rdata_o(p1_rdata[g]),
            .p2_req_i(p2_req[g]), .p2_gnt_o(p2_gnt[g]), .p2_rvalid_o(p2_rvalid[g]),
            .p2_err_o(p2_err[g]), .p2_we_i(p2_we[g]), .p2_be_i(p2_be[g]),
            .p2_addr_i(p2_addr[g]), .p2_wdata_i(p2_wdata[g]), .p2_rdata_o(p2_rdata[g]),
            .mem_req_o(mem_req[g]), .mem_we_o(mem_we[g]), .mem_be_o(mem_be[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]),
            .conflict_cnt_o(cnt_o[g])
        );

        // SRAM model: byte-masked writes, reads returned L cycles after the strobe.
        always @(posedge clk) begin
            if (preload) begin
                for (int k = 0; k < MW; k++) mem[k] <= init_img[k];
            end else if (mem_req[g] && mem_we[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            rd_pipe[0] <= (mem_req[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hBAD0_BAD0;
            for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mem_rdata[g] = rd_pipe[L-1];
    end

    typedef struct {
        int          due;
        bit          port;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          prio [2];
    longint      cnt_m [2];
    int          cyc [2];
    logic [31:0] ref_mem [2][MW];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drv(input int i, input int p, input logic req, input logic we,
                       input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            p1_req[i] = req; p1_we[i] = we; p1_be[i] = be; p1_addr[i] = addr; p1_wdata[i] = wd;
        end else begin
            p2_req[i] = req; p2_we[i] = we; p2_be[i] = be; p2_addr[i] = addr; p2_wdata[i] = wd;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return $urandom | 32'h0000_0100;
        return 32'($urandom_range(0, MW*4 - 1));
    endfunction

    // One clock: compare DUT against the model at the falling edge, then advance the model.
    task automatic step(input int i, output int win);
        logic [31:0] a, wd;
        logic        we, r1, r2;
        logic [3:0]  be;
        bit          inr;
        int          exp_port, lat, w;
        exp_t        e;
        lat = (i == 0) ? 1 : 3;
        @(negedge clk);
        r1 = p1_req[i];
        r2 = p2_req[i];
        win = -1;
        if (en[i]) begin
            if (r1 && r2) win = prio[i];
            else if (r1)  win = 0;
            else if (r2)  win = 1;
        end
        chk_eq("p1_gnt", p1_gnt[i], win == 0);
        chk_eq("p2_gnt", p2_gnt[i], win == 1);
        if (win == 1) begin a = p2_addr[i]; wd = p2_wdata[i]; we = p2_we[i]; be = p2_be[i]; end
        else          begin a = p1_addr[i]; wd = p1_wdata[i]; we = p1_we[i]; be = p1_be[i]; end
        inr = (a < 32'(MW*4));
        chk_eq("mem_req", mem_req[i], (win >= 0) && inr);
        if (win >= 0 && inr) begin
            chk_eq("mem_addr", mem_addr[i], a[AWT+1:2]);
            chk_eq("mem_we", mem_we[i], we);
            chk_eq("mem_be", mem_be[i], be);
            if (we) chk_eq("mem_wdata", mem_wdata[i], wd);
        end
        exp_port = -1;
        e.data = 32'h0;
        e.err  = 1'b0;
        if (q.size() > 0 && q[0].due == cyc[i]) begin
            e = q.pop_front();
            exp_port = e.port;
        end
        chk_eq("p1_rvalid", p1_rvalid[i], exp_port == 0);
        chk_eq("p2_rvalid", p2_rvalid[i], exp_port == 1);
        chk_eq("p1_rdata", p1_rdata[i], (exp_port == 0) ? e.data : 32'h0);
        chk_eq("p2_rdata", p2_rdata[i], (exp_port == 1) ? e.data : 32'h0);
        if (exp_port == 0) chk_eq("p1_err", p1_err[i], e.err);
        if (exp_port == 1) chk_eq("p2_err", p2_err[i], e.err);
        chk_eq("conflict_cnt", cnt_o[i], 32'(cnt_m[i]));
        if (r1 && r2 && cnt_m[i] < 64'hFFFF_FFFF) cnt_m[i]++;
        if (win >= 0) begin
            prio[i] = 1 - win;
            e.due  = cyc[i] + lat;
            e.port = win[0];
            e.err  = !inr;
            e.data = 32'h0;
            if (inr) begin
                w = int'(a[AWT+1:2]);
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[i][w][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e.data = ref_mem[i][w];
                end
            end
            q.push_back(e);
        end
        cyc[i]++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int i);
        drv(i, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(i, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        en[i]    = 1'b1;
        rst_n[i] = 1'b0;
        @(negedge clk);
        chk_eq("rst_p1_rvalid", p1_rvalid[i], 1'b0);
        chk_eq("rst_p2_rvalid", p2_rvalid[i], 1'b0);
        chk_eq("rst_p1_rdata", p1_rdata[i], 32'h0);
        chk_eq("rst_p2_rdata", p2_rdata[i], 32'h0);
        chk_eq("rst_mem_req", mem_req[i], 1'b0);
        chk_eq("rst_cnt", cnt_o[i], 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n[i] = 1'b1;
        prio[i]  = 0;
        cnt_m[i] = 0;
        q.delete();
    endtask

    task automatic idle(input int i, input int n);
        int w;
        drv(i, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(i, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < n; k++) step(i, w);
    endtask

    initial begin
        int w;
        preload = 1'b1;
        for (int k = 0; k < MW; k++) init_img[k] = $urandom;
        init_img[4] = 32'hDEAD_BEEF;
        init_img[2] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < MW; k++) ref_mem[i][k] = init_img[k];
            cyc[i] = 0;
            rst_n[i] = 1'b0;
            en[i] = 1'b1;
            drv(i, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            drv(i, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        @(posedge clk);
        #1;
        preload = 1'b0;
        do_reset(0);
        do_reset(1);

        // Single read of the preloaded word.
        drv(0, 0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        step(0, w);
        idle(0, 3);

        // Contention from reset: alternating grants.
        do_reset(0);
        drv(0, 0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        drv(0, 1, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
        for (int k = 0; k < 4; k++) step(0, w);
        idle(0, 3);

        // Partial write by port 2 then read-back by port 1.
        drv(0, 1, 1'b1, 1'b1, 4'b0011, 32'h8, 32'hA5A5_A5A5);
        step(0, w);
        drv(0, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(0, 0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        step(0, w);
        idle(0, 2);

        // First out-of-range byte address.
        drv(0, 0, 1'b1, 1'b0, 4'hF, 32'(MW*4), 32'h0);
        step(0, w);
        idle(0, 2);

        // Disabled with both requesting, then enabled.
        do_reset(0);
        en[0] = 1'b0;
        drv(0, 0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        drv(0, 1, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
        for (int k = 0; k < 5; k++) step(0, w);
        en[0] = 1'b1;
        step(0, w);
        drv(0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(0, w);
        idle(0, 3);

        // Randomised traffic; a request is held until granted.
        for (int n = 0; n < 1500; n++) begin
            logic g1, g2;
            step(0, w);
            g1 = (w == 0);
            g2 = (w == 1);
            if (!p1_req[0] || g1)
                drv(0, 0, $urandom_range(0, 2) != 0, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
            if (!p2_req[0] || g2)
                drv(0, 1, $urandom_range(0, 2) != 0, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
            en[0] = ($urandom_range(0, 9) != 0);
        end
        en[0] = 1'b1;
        idle(0, 4);

        // Latency 3: reset drops responses in flight.
        drv(1, 0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        step(1, w);
        drv(1, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(1, 1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        step(1, w);
        drv(1, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_n[1] = 1'b0;
        prio[1]  = 0;
        cnt_m[1] = 0;
        q.delete();
        for (int k = 0; k < 4; k++) step(1, w);
        rst_n[1] = 1'b1;
        idle(1, 2);
        drv(1, 0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        drv(1, 1, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
        step(1, w);
        step(1, w);
        idle(1, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
